// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO between host-side writes and a UART transmitter.
// Sticky Ovf/Udf error flags are built only when TX_FIFO_ERR_FLAGS_EN is defined.
module tx_fifo #(
   parameter int DEPTH    = 16,
   parameter int AFULL_TH = 12
) (
   input  logic                     Clk,
   input  logic                     RstB,
   input  logic                     WrEn,
   input  logic [7:0]               WrData,
   output logic                     WrFull,
   output logic                     WrAFull,
   input  logic                     RdEn,
   output logic [7:0]               RdData,
   output logic                     Empty,
   output logic [$clog2(DEPTH):0]   Count,
   input  logic                     ErrClr,
   output logic                     Ovf,
   output logic                     Udf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] count_q, count_d;
   logic        empty_q, empty_d;
   logic        full_q, full_d;
   logic        afull_q, afull_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        wr_acc, rd_acc;

   // Pointers carry a wrap bit: equal pointers mean empty, differing only in the wrap bit means full.
   always_comb begin
      wr_acc    = WrEn && !full_q;
      rd_acc    = RdEn && !empty_q;
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, wr_acc};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rd_acc};
      count_d   = wr_ptr_d - rd_ptr_d;
      empty_d   = (wr_ptr_d == rd_ptr_d);
      full_d    = (wr_ptr_d == {~rd_ptr_d[AW], rd_ptr_d[AW-1:0]});
      afull_d   = (count_d >= AFULL_LVL);
      rd_data_d = rd_acc ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
   end

   always_ff @(posedge Clk) begin
      if (RstB) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         afull_q   <= 1'b0;
         rd_data_q <= 8'h00;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         afull_q   <= afull_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage has no reset so it maps onto a simple dual-port RAM.
   always_ff @(posedge Clk) begin
      if (wr_acc && !RstB) begin
         mem_q[wr_ptr_q[AW-1:0]] <= WrData;
      end
   end

   assign WrFull  = full_q;
   assign WrAFull = afull_q;
   assign Empty   = empty_q;
   assign Count   = count_q;
   assign RdData  = rd_data_q;

`ifdef TX_FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   // A new error event outranks a clear arriving in the same cycle.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (ErrClr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      if (WrEn && full_q) begin
         ovf_d = 1'b1;
      end
      if (RdEn && empty_q) begin
         udf_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (RstB) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign Ovf = ovf_q;
   assign Udf = udf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = ErrClr;
   assign Ovf = 1'b0;
   assign Udf = 1'b0;
`endif

endmodule

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 8-bit entries (power of two, 4..256).
REQ-002 SHALL have parameter AFULL_TH, default 12, occupancy at or above which WrAFull asserts (1..DEPTH-1).
REQ-003 SHALL have a single clock and a synchronous active-high reset; all logic on posedge Clk.
REQ-004 Clk  input  1  system clock.
REQ-005 RstB  input  1  synchronous reset, active-high.
REQ-006 WrEn  input  1  write request from host side.
REQ-007 WrData  input  8  byte to enqueue.
REQ-008 WrFull  output  1  FIFO holds DEPTH entries.
REQ-009 WrAFull  output  1  occupancy >= AFULL_TH.
REQ-010 RdEn  input  1  single-cycle read pulse from UART transmitter.
REQ-011 RdData  output  8  head byte, registered, valid the cycle after an accepted RdEn.
REQ-012 Empty  output  1  FIFO holds zero entries; drives transmitter's TxFfEmpty.
REQ-013 Count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 ErrClr  input  1  clears sticky error flags.
REQ-015 Ovf  output  1  sticky: write attempted while full.
REQ-016 Udf  output  1  sticky: read attempted while empty.

Function
REQ-017 Write accepted iff WrEn=1 and WrFull=1'b0 at the edge; WrData stored at write pointer, pointer increments modulo DEPTH.
REQ-018 Write with WrFull=1 SHALL be dropped: no storage, pointer and Count unchanged, even if RdEn=1 in the same cycle.
REQ-019 Read accepted iff RdEn=1 and Empty=0 at the edge; RdData loads the head entry at that edge (1-cycle latency), read pointer increments modulo DEPTH.
REQ-020 Read with Empty=1 SHALL be ignored: pointers, Count and RdData unchanged, even if WrEn=1 in the same cycle.
REQ-021 RdData SHALL hold its last value when no read is accepted.
REQ-022 Simultaneous accepted read and write: Count unchanged, both pointers advance.
REQ-023 Count, Empty, WrFull, WrAFull SHALL be registered and reflect occupancy after the current edge (Empty=1 iff Count=0, WrFull=1 iff Count=DEPTH).
REQ-024 Pointers SHALL be log2(DEPTH)+1 bits with wrap bit; full/empty distinguished by wrap bit, wrap-around seamless.
REQ-025 Data written in cycle N SHALL be readable (Empty=0) at cycle N+1.
REQ-026 Storage SHALL be inferable as simple dual-port RAM; no reset on storage array.

Reset
REQ-027 RstB=1 SHALL set pointers 0, Count=0, Empty=1, WrFull=0, WrAFull=0, RdData=8'h00, Ovf=0, Udf=0.
REQ-028 RstB=1 mid-operation SHALL discard all entries at that edge; WrEn/RdEn ignored in reset cycles.

Configuration
REQ-029 Macro TX_FIFO_ERR_FLAGS_EN defined: Ovf set by REQ-018 event, Udf set by REQ-020 event, both cleared by ErrClr=1; set wins over clear in the same cycle.
REQ-030 Macro TX_FIFO_ERR_FLAGS_EN undefined: Ovf and Udf tied 1'b0, ErrClr ignored, no flag logic.

Verification
REQ-031 Reset, write 8'hA5, then RdEn pulse -> Empty=0 one cycle after write; RdData=8'hA5 the cycle after RdEn; Empty=1, Count=0.
REQ-032 Write 16 bytes 0x00..0x0F (DEPTH=16) -> WrAFull at Count=12, WrFull at 16; 17th write 0xFF dropped, Ovf=1; readout yields 0x00..0x0F in order.
REQ-033 RdEn with Empty=1 and RdData=8'h3C -> RdData stays 8'h3C, Count stays 0, Udf=1; ErrClr pulse -> Udf=0.
REQ-034 Count=5, WrEn and RdEn together for 40 cycles -> Count stays 5, pointers wrap past 16 twice, data order preserved.
REQ-035 Count=9, assert RstB one cycle -> Count=0, Empty=1, RdData=8'h00; next write/read returns new byte only.
REQ-036 Full FIFO, WrEn and RdEn together -> read accepted, write dropped, Count=15, Ovf=1 (flags build).
